// File: rtl/fetch_sequencer_if.sv
// Fetch bus bundle: decode requests, memory byte port and instruction register
// load port. The master side is the fetch sequencer.
interface fetch_sequencer_if;
    logic        fetch_req;
    logic        branch;
    logic [15:0] branch_addr;
    logic [7:0]  mem_data;
    logic        mem_ready;
    logic        inst_ack;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  ir_i;
    logic        ir_write;
    logic        ir_lh;
    logic [15:0] pc;
    logic        inst_valid;
    logic        busy;

    modport master (
        input  fetch_req, branch, branch_addr, mem_data, mem_ready, inst_ack,
        output mem_addr, mem_rd, ir_i, ir_write, ir_lh, pc, inst_valid, busy
    );

    modport slave (
        output fetch_req, branch, branch_addr, mem_data, mem_ready, inst_ack,
        input  mem_addr, mem_rd, ir_i, ir_write, ir_lh, pc, inst_valid, busy
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks the PC through byte-wide memory, loads the
// 16-bit instruction register LSB first, then hands the word to decode.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no fetch pending; a branch only reloads the PC
// FETCH_L  | reading the low byte at PC (lower address)
// FETCH_H  | reading the high byte at PC
// VALID    | instruction register complete, waiting for decode to ack
module fetch_sequencer #(
    parameter logic [15:0] RESET_VEC = 16'h0000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    fetch_sequencer_if.master fetch
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH_L = 2'd1,
        ST_FETCH_H = 2'd2,
        ST_VALID   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_pc;
    logic [15:0] w_pc_nxt;
    logic        w_fetching;

    // State and PC registers; reset is asynchronous so outputs clear at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_VEC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Next state and PC; branch outranks every other request in every state.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        case (r_state)
            ST_IDLE: begin
                if (fetch.branch) begin
                    w_pc_nxt = fetch.branch_addr;
                end else if (fetch.fetch_req) begin
                    w_state_nxt = ST_FETCH_L;
                end
            end
            ST_FETCH_L: begin
                if (fetch.branch) begin
                    w_pc_nxt    = fetch.branch_addr;
                    w_state_nxt = ST_FETCH_L;
                end else if (fetch.mem_ready) begin
                    w_pc_nxt    = r_pc + 16'd1;
                    w_state_nxt = ST_FETCH_H;
                end
            end
            ST_FETCH_H: begin
                // A branch here throws away the low byte already loaded.
                if (fetch.branch) begin
                    w_pc_nxt    = fetch.branch_addr;
                    w_state_nxt = ST_FETCH_L;
                end else if (fetch.mem_ready) begin
                    w_pc_nxt    = r_pc + 16'd1;
                    w_state_nxt = ST_VALID;
                end
            end
            ST_VALID: begin
                if (fetch.branch) begin
                    w_pc_nxt    = fetch.branch_addr;
                    w_state_nxt = ST_IDLE;
                end else if (fetch.inst_ack) begin
                    w_state_nxt = fetch.fetch_req ? ST_FETCH_L : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from state and live inputs; no IR write outside fetch states.
    always_comb begin
        w_fetching       = (r_state == ST_FETCH_L) || (r_state == ST_FETCH_H);
        fetch.mem_addr   = r_pc;
        fetch.pc         = r_pc;
        fetch.mem_rd     = w_fetching;
        fetch.busy       = w_fetching;
        fetch.ir_i       = fetch.mem_data;
        fetch.ir_lh      = (r_state == ST_FETCH_H);
        fetch.ir_write   = fetch.mem_ready & ~fetch.branch & w_fetching;
        fetch.inst_valid = (r_state == ST_VALID);
    end

endmodule
